ram_portb_arbiter: RTL
======================

RAM_PORTB_ARBITER -- requirements
Module: ram_portb_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 13, RAM port-B address width.
REQ-002 Parameter: STARVE_LIMIT, default 15, consecutive denied cycles before the hiscore request overrides video.
REQ-003 Clock  in  1  single system clock; all logic is rising-edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 vid_req  in  1  video read-ahead request, sampled every cycle.
REQ-006 vid_addr  in  ADDR_W  video read address.
REQ-007 vid_data  out  8  video read data.
REQ-008 vid_valid  out  1  one-cycle pulse; vid_data is updated this cycle.
REQ-009 vid_miss  out  1  with vid_valid; the request was preempted and vid_data is held.
REQ-010 hs_enable  in  1  hiscore engine owns the access window.
REQ-011 hs_req  in  1  hiscore transaction request, level, held until hs_ack.
REQ-012 hs_write  in  1  1 = write, 0 = read; sampled with hs_req.
REQ-013 hs_addr  in  ADDR_W  hiscore address.
REQ-014 hs_wdata  in  8  hiscore write data.
REQ-015 hs_rdata  out  8  hiscore read data; valid with hs_ack.
REQ-016 hs_ack  out  1  one-cycle pulse; transaction complete.
REQ-017 ram_addr  out  ADDR_W  registered port-B address.
REQ-018 ram_wren  out  1  registered port-B write enable.
REQ-019 ram_wdata  out  8  registered port-B write data.
REQ-020 ram_q  in  8  port-B read data; one-cycle synchronous read latency.

Function
REQ-021 Pipeline: the arbiter SHALL grant in cycle N, drive ram_addr/ram_wren/ram_wdata in N+1, and sample ram_q and pulse vid_valid or hs_ack in N+2.
REQ-022 Exactly one requester SHALL be granted per cycle, and a new grant SHALL be possible every cycle (throughput 1 per cycle).
REQ-023 Hiscore FSM: HS_IDLE -> HS_WAIT on hs_req&hs_enable; HS_WAIT -> HS_ISSUE on grant; HS_ISSUE -> HS_RESP; HS_RESP -> HS_IDLE with hs_ack=1.
REQ-024 Priority: vid_req SHALL win over HS_WAIT unless starve_cnt == STARVE_LIMIT.
REQ-025 starve_cnt (width ceil(log2(STARVE_LIMIT+1))) SHALL increment for each cycle spent in HS_WAIT with the grant denied, saturate at STARVE_LIMIT, and clear on hiscore grant.
REQ-026 Starvation override: a vid_req denied in cycle N SHALL produce vid_valid=1 and vid_miss=1 at N+2, with vid_data unchanged.
REQ-027 A hiscore read SHALL load hs_rdata from ram_q at N+2; a hiscore write SHALL assert ram_wren for exactly one cycle (N+1) with ram_wdata=hs_wdata, and hs_rdata is don't-care on ack.
REQ-028 ram_wren SHALL never be asserted for a video grant; when idle, ram_addr SHALL hold its last value and ram_wren=0.
REQ-029 hs_req SHALL be ignored outside HS_IDLE and whenever hs_enable=0.
REQ-030 An hs_enable fall in HS_ISSUE or HS_RESP SHALL NOT abort the transaction, which completes with hs_ack; in HS_WAIT it SHALL return the FSM to HS_IDLE without ack.
REQ-031 An hs_req held high through hs_ack SHALL start a new transaction, sampled in the cycle after the ack (minimum 4-cycle hiscore turnaround).
REQ-032 With vid_req=0 in HS_WAIT, the hiscore request SHALL be granted in that same cycle.

Reset
REQ-033 Reset_n=0 SHALL asynchronously force the FSM to HS_IDLE, starve_cnt=0, both pipeline stages empty, ram_wren=0, ram_addr=0, ram_wdata=0, vid_data=0, hs_rdata=0, and vid_valid=vid_miss=hs_ack=0.
REQ-034 An in-flight transaction interrupted by reset SHALL be discarded with no ack and no write after release.
REQ-035 Outputs SHALL update on the first rising edge after reset release.

Verification
REQ-036 Video only: vid_req=1 with vid_addr=0x0100 and ram_q returning 0x5A -> vid_valid at N+2, vid_data=0x5A, vid_miss=0.
REQ-037 Hiscore write while idle: hs_addr=0x03F0, hs_wdata=0xC3 -> ram_wren=1 for one cycle with ram_addr=0x03F0 and ram_wdata=0xC3, hs_ack 2 cycles after grant, re-read returns 0xC3.
REQ-038 Starvation: vid_req held at 1 with a hiscore read pending -> 15 denied cycles, grant on the 16th, exactly one vid_valid with vid_miss=1 and vid_data unchanged, starve_cnt=0 afterwards.
REQ-039 hs_enable dropped in HS_WAIT -> no hs_ack and no ram access; dropped in HS_ISSUE -> hs_ack still pulses once.
REQ-040 Reset_n low during HS_ISSUE of a write -> ram_wren=0 immediately, no hs_ack after release, and all outputs at their REQ-033 values.

Source files
------------

// File: rtl/ram_portb_arbiter_if.sv
// ram_portb_arbiter_if
//   Signal bundle for the RAM port-B arbiter: the video read-ahead requester,
//   the hiscore engine requester, and the registered RAM port-B pins.
//   modport slave  : the arbiter side.
//   modport master : the requesters + RAM side (environment / testbench).
//   Video   : vid_req, vid_addr -> vid_data, vid_valid, vid_miss
//   Hiscore : hs_enable, hs_req, hs_write, hs_addr, hs_wdata -> hs_rdata, hs_ack
//   RAM     : ram_addr, ram_wren, ram_wdata -> ram_q (1-cycle read latency)
interface ram_portb_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_data;
  logic              vid_valid;
  logic              vid_miss;

  logic              hs_enable;
  logic              hs_req;
  logic              hs_write;
  logic [ADDR_W-1:0] hs_addr;
  logic [7:0]        hs_wdata;
  logic [7:0]        hs_rdata;
  logic              hs_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_q;

  modport slave (
    input  vid_req, vid_addr, hs_enable, hs_req, hs_write, hs_addr, hs_wdata, ram_q,
    output vid_data, vid_valid, vid_miss, hs_rdata, hs_ack, ram_addr, ram_wren, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, hs_enable, hs_req, hs_write, hs_addr, hs_wdata, ram_q,
    input  vid_data, vid_valid, vid_miss, hs_rdata, hs_ack, ram_addr, ram_wren, ram_wdata
  );
endinterface

// File: rtl/ram_portb_arbiter.sv
// ram_portb_arbiter
//   Shares RAM port B between a video read-ahead stream and a hiscore engine.
//   Grant in cycle N, RAM pins registered for N+1, response (vid_valid or
//   hs_ack) in N+2 together with the RAM read data. Video normally wins; a
//   hiscore request starved for STARVE_LIMIT cycles overrides video, and the
//   preempted video request is answered with vid_valid + vid_miss.
//   Ports: clk, rst_n (async, active low), bus (ram_portb_arbiter_if.slave).
//
//   state    | meaning
//   HS_IDLE  | no hiscore transaction; accepts hs_req & hs_enable
//   HS_WAIT  | request captured, competing with video for the port
//   HS_ISSUE | granted; command is on the RAM pins this cycle
//   HS_RESP  | RAM data available; hs_ack pulses
module ram_portb_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  ram_portb_arbiter_if.slave  bus
);
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {HS_IDLE, HS_WAIT, HS_ISSUE, HS_RESP} hs_state_t;

  hs_state_t         state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              hs_write_q, hs_write_d;
  logic [ADDR_W-1:0] hs_addr_q, hs_addr_d;
  logic [7:0]        hs_wdata_q, hs_wdata_d;

  // stage 1: RAM command
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wren_q, ram_wren_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              s1_vid_q, s1_vid_d;
  logic              s1_miss_q, s1_miss_d;

  // stage 2: response
  logic              vid_valid_q, vid_valid_d;
  logic              vid_miss_q, vid_miss_d;
  logic              hs_ack_q, hs_ack_d;
  logic              s2_rd_q, s2_rd_d;
  logic [7:0]        vid_data_q, vid_data_d;
  logic [7:0]        hs_rdata_q, hs_rdata_d;

  logic              hs_grant, vid_grant, vid_deny;
  logic              vid_take, hs_take;

  always_comb begin
    hs_grant  = (state_q == HS_WAIT) && bus.hs_enable &&
                (!bus.vid_req || (starve_q == STARVE_MAX));
    vid_grant = bus.vid_req && !hs_grant;
    vid_deny  = bus.vid_req && hs_grant;
    vid_take  = vid_valid_q && !vid_miss_q;
    hs_take   = hs_ack_q && s2_rd_q;
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    hs_write_d = hs_write_q;
    hs_addr_d  = hs_addr_q;
    hs_wdata_d = hs_wdata_q;
    unique case (state_q)
      HS_IDLE: begin
        if (bus.hs_req && bus.hs_enable) begin
          state_d    = HS_WAIT;
          hs_write_d = bus.hs_write;
          hs_addr_d  = bus.hs_addr;
          hs_wdata_d = bus.hs_wdata;
        end
      end
      HS_WAIT: begin
        if (!bus.hs_enable)               state_d  = HS_IDLE;
        else if (hs_grant)                state_d  = HS_ISSUE;
        else if (starve_q != STARVE_MAX)  starve_d = starve_q + CNT_W'(1);
      end
      HS_ISSUE: state_d = HS_RESP;
      HS_RESP:  state_d = HS_IDLE;
      default:  state_d = HS_IDLE;
    endcase
    // An abandoned wait must not leave a stale count for the next request.
    if (state_d != HS_WAIT) starve_d = '0;
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wren_d  = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (hs_grant) begin
      ram_addr_d = hs_addr_q;
      ram_wren_d = hs_write_q;
      if (hs_write_q) ram_wdata_d = hs_wdata_q;
    end else if (vid_grant) begin
      ram_addr_d = bus.vid_addr;
    end
    s1_vid_d  = vid_grant;
    s1_miss_d = vid_deny;

    vid_valid_d = s1_vid_q || s1_miss_q;
    vid_miss_d  = s1_miss_q;
    hs_ack_d    = (state_q == HS_ISSUE);
    s2_rd_d     = (state_q == HS_ISSUE) && !hs_write_q;
    vid_data_d  = vid_take ? bus.ram_q : vid_data_q;
    hs_rdata_d  = hs_take  ? bus.ram_q : hs_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HS_IDLE;
      starve_q    <= '0;
      hs_write_q  <= 1'b0;
      hs_addr_q   <= '0;
      hs_wdata_q  <= '0;
      ram_addr_q  <= '0;
      ram_wren_q  <= 1'b0;
      ram_wdata_q <= '0;
      s1_vid_q    <= 1'b0;
      s1_miss_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_miss_q  <= 1'b0;
      hs_ack_q    <= 1'b0;
      s2_rd_q     <= 1'b0;
      vid_data_q  <= '0;
      hs_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      hs_write_q  <= hs_write_d;
      hs_addr_q   <= hs_addr_d;
      hs_wdata_q  <= hs_wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wren_q  <= ram_wren_d;
      ram_wdata_q <= ram_wdata_d;
      s1_vid_q    <= s1_vid_d;
      s1_miss_q   <= s1_miss_d;
      vid_valid_q <= vid_valid_d;
      vid_miss_q  <= vid_miss_d;
      hs_ack_q    <= hs_ack_d;
      s2_rd_q     <= s2_rd_d;
      vid_data_q  <= vid_data_d;
      hs_rdata_q  <= hs_rdata_d;
    end
  end

  // RAM data is only valid in the response cycle, so it is forwarded
  // straight through then and held in the *_q registers afterwards.
  assign bus.vid_data  = vid_take ? bus.ram_q : vid_data_q;
  assign bus.hs_rdata  = hs_take  ? bus.ram_q : hs_rdata_q;
  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_miss  = vid_miss_q;
  assign bus.hs_ack    = hs_ack_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wren  = ram_wren_q;
  assign bus.ram_wdata = ram_wdata_q;
endmodule
